// File: rtl/reator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reator_pkg: shared types, defaults and popcount for the pump arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reator_pkg;

    typedef enum logic [1:0] {
        LIVRE    = 2'd0,
        ESPERA   = 2'd1,
        PARTIDA  = 2'd2,
        OPERANDO = 2'd3
    } estado_t;

    localparam int C_N_REATORES  = 4;
    localparam int C_N_BOMBAS    = 2;
    localparam int C_T_MIN       = 8;
    localparam int C_POP_LARGURA = 32;

    // Vectors up to 32 bits; callers zero-extend narrower ones.
    function automatic int unsigned popcount(input logic [C_POP_LARGURA-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < C_POP_LARGURA; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seletor_rr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seletor_rr: combinational circular selector, at most i_max grants   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seletor_rr
    import reator_pkg::*;
#(
    parameter int N = C_N_REATORES
)(
    input  logic [N-1:0]             i_req,
    input  logic [$clog2(N)-1:0]     i_inicio,
    input  logic [$clog2(N+1)-1:0]   i_max,
    output logic [N-1:0]             o_sel,
    output logic [$clog2(N)-1:0]     o_ultimo
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);

    logic [IW:0]   w_idx;
    logic [CW-1:0] w_qtd;

    always_comb begin
        o_sel    = '0;
        o_ultimo = i_inicio;
        w_qtd    = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, i_inicio} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N)) begin
                w_idx = w_idx - (IW+1)'(N);
            end
            if (i_req[w_idx[IW-1:0]] && (w_qtd < i_max)) begin
                o_sel[w_idx[IW-1:0]] = 1'b1;
                w_qtd                = w_qtd + CW'(1);
                o_ultimo             = w_idx[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitro_bombas_refrigeracao.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbitro_bombas_refrigeracao: critical-first round-robin pump arbiter|
// | with minimum run time. Optional: PREEMPCAO_CRITICA_EN. Rev 1.0     |
// +--------------------------------------------------------------------+
module arbitro_bombas_refrigeracao
    import reator_pkg::*;
#(
    parameter int N_REATORES = C_N_REATORES,
    parameter int N_BOMBAS   = C_N_BOMBAS,
    parameter int T_MIN      = C_T_MIN
)(
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic [N_REATORES-1:0]         pedido,
    input  logic [N_REATORES-1:0]         critico,
    output logic [N_REATORES-1:0]         concessao,
    output logic [$clog2(N_BOMBAS+1)-1:0] ocupadas,
    output logic                          sobrecarga
);

    localparam int IW = $clog2(N_REATORES);
    localparam int CW = $clog2(N_REATORES+1);
    localparam int OW = $clog2(N_BOMBAS+1);
    localparam int KW = (T_MIN > 1) ? $clog2(T_MIN) : 1;

    logic [N_REATORES-1:0] w_dem;
    logic [N_REATORES-1:0] w_espera;
    logic [N_REATORES-1:0] w_operando;
    logic [N_REATORES-1:0] w_esp_crit;
    logic [N_REATORES-1:0] w_esp_norm;
    logic [N_REATORES-1:0] w_sel_crit;
    logic [N_REATORES-1:0] w_sel_norm;
    logic [N_REATORES-1:0] w_sel;
    logic [N_REATORES-1:0] w_revoga;
    logic [N_REATORES-1:0] w_conc;
    logic [N_REATORES-1:0] w_conc_prox;

    logic [OW-1:0] w_livres;
    logic [CW-1:0] w_max_crit;
    logic [CW-1:0] w_qtd_crit;
    logic [CW-1:0] w_max_norm;
    logic [IW-1:0] w_ult_crit;
    logic [IW-1:0] w_ult_norm;
    logic [IW-1:0] w_ult;
    logic [IW-1:0] w_rr_prox;

    logic [IW-1:0] r_rr_ptr;
    logic [OW-1:0] r_ocupadas;
    logic          r_sobrecarga;

    assign w_dem      = pedido | critico;
    assign w_esp_crit = w_espera & critico;
    assign w_esp_norm = w_espera & pedido & ~critico;

    // Free pumps come from registered occupancy: a release is visible one cycle later.
    assign w_livres   = OW'(N_BOMBAS) - r_ocupadas;
    assign w_max_crit = CW'(w_livres);
    assign w_qtd_crit = CW'(popcount(32'(w_sel_crit)));
    assign w_max_norm = w_max_crit - w_qtd_crit;
    assign w_sel      = w_sel_crit | w_sel_norm;

    seletor_rr #(.N(N_REATORES)) u_sel_crit (
        .i_req    (w_esp_crit),
        .i_inicio (r_rr_ptr),
        .i_max    (w_max_crit),
        .o_sel    (w_sel_crit),
        .o_ultimo (w_ult_crit)
    );

    seletor_rr #(.N(N_REATORES)) u_sel_norm (
        .i_req    (w_esp_norm),
        .i_inicio (r_rr_ptr),
        .i_max    (w_max_norm),
        .o_sel    (w_sel_norm),
        .o_ultimo (w_ult_norm)
    );

    // Normal waiters are served after critical ones, so they hold the last index when present.
    always_comb begin
        w_ult     = (|w_sel_norm) ? w_ult_norm : w_ult_crit;
        w_rr_prox = r_rr_ptr;
        if (|w_sel) begin
            w_rr_prox = (w_ult == IW'(N_REATORES-1)) ? '0 : w_ult + IW'(1);
        end
    end

`ifdef PREEMPCAO_CRITICA_EN
    logic w_achou;

    always_comb begin
        w_revoga = '0;
        w_achou  = 1'b0;
        if ((|w_esp_crit) && (w_livres == '0)) begin
            for (int i = 0; i < N_REATORES; i++) begin
                if (!w_achou && w_operando[i] && !critico[i]) begin
                    w_revoga[i] = 1'b1;
                    w_achou     = 1'b1;
                end
            end
        end
    end
`else
    assign w_revoga = '0;
`endif

    generate
        for (genvar i = 0; i < N_REATORES; i++) begin : g_reator
            estado_t       r_estado;
            estado_t       w_prox;
            logic [KW-1:0] r_cnt;
            logic [KW-1:0] w_cnt_prox;

            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    r_estado <= LIVRE;
                    r_cnt    <= '0;
                end else begin
                    r_estado <= w_prox;
                    r_cnt    <= w_cnt_prox;
                end
            end

            always_comb begin
                w_prox     = r_estado;
                w_cnt_prox = r_cnt;
                case (r_estado)
                    LIVRE: begin
                        if (w_dem[i]) w_prox = ESPERA;
                    end
                    ESPERA: begin
                        if (w_sel[i]) begin
                            w_prox     = PARTIDA;
                            w_cnt_prox = KW'(T_MIN-1);
                        end else if (!w_dem[i]) begin
                            w_prox = LIVRE;
                        end
                    end
                    PARTIDA: begin
                        if (r_cnt == '0) w_prox = OPERANDO;
                        else             w_cnt_prox = r_cnt - KW'(1);
                    end
                    OPERANDO: begin
                        if (!w_dem[i])        w_prox = LIVRE;
                        else if (w_revoga[i]) w_prox = ESPERA;
                    end
                    default: w_prox = LIVRE;
                endcase
            end

            assign w_espera[i]    = (r_estado == ESPERA);
            assign w_operando[i]  = (r_estado == OPERANDO);
            assign w_conc[i]      = (r_estado == PARTIDA) || (r_estado == OPERANDO);
            assign w_conc_prox[i] = (w_prox == PARTIDA) || (w_prox == OPERANDO);
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rr_ptr     <= '0;
            r_ocupadas   <= '0;
            r_sobrecarga <= 1'b0;
        end else begin
            r_rr_ptr     <= w_rr_prox;
            r_ocupadas   <= OW'(popcount(32'(w_conc_prox)));
            r_sobrecarga <= (popcount(32'(critico)) > 32'(N_BOMBAS));
        end
    end

    assign concessao  = w_conc;
    assign ocupadas   = r_ocupadas;
    assign sobrecarga = r_sobrecarga;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_bombas_refrigeracao.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arbitro_bombas_refrigeracao: scoreboard bench for the pump arbiter|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_arbitro_bombas_refrigeracao;

    localparam int NR = 4;
    localparam int NB = 2;
    localparam int TM = 8;
    localparam int OW = $clog2(NB+1);

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic [NR-1:0] pedido;
    logic [NR-1:0] critico;
    logic [NR-1:0] concessao;
    logic [OW-1:0] ocupadas;
    logic          sobrecarga;

    typedef struct packed {
        logic [NR-1:0] conc;
        logic [OW-1:0] ocup;
        logic          sob;
    } saida_t;

    saida_t fila[$];
    int n_vet  = 0;
    int n_erro = 0;

    // Reference: m_st 0=free 1=waiting 2=granted; m_t counts edges since grant.
    int m_st [NR];
    int m_t  [NR];
    int m_ptr;
    int m_ocup;
    int m_sob;

    arbitro_bombas_refrigeracao #(
        .N_REATORES (NR),
        .N_BOMBAS   (NB),
        .T_MIN      (TM)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .pedido     (pedido),
        .critico    (critico),
        .concessao  (concessao),
        .ocupadas   (ocupadas),
        .sobrecarga (sobrecarga)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vet++;
        if (obs !== esp) begin
            n_erro++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_passo(input logic [NR-1:0] p, input logic [NR-1:0] c, input logic r);
        saida_t e;
        int livres, cnt, ult, rev, pc;
        bit sel [NR];
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                m_st[i] = 0;
                m_t[i]  = 0;
            end
            m_ptr  = 0;
            m_ocup = 0;
            m_sob  = 0;
        end else begin
            livres = NB - m_ocup;
            cnt = 0;
            ult = -1;
            rev = -1;
            for (int i = 0; i < NR; i++) sel[i] = 1'b0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (m_st[i] == 1 && c[i] && cnt < livres) begin
                    sel[i] = 1'b1; cnt++; ult = i;
                end
            end
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (m_st[i] == 1 && p[i] && !c[i] && cnt < livres) begin
                    sel[i] = 1'b1; cnt++; ult = i;
                end
            end
`ifdef PREEMPCAO_CRITICA_EN
            begin
                bit crit_esp;
                crit_esp = 1'b0;
                for (int i = 0; i < NR; i++) if (m_st[i] == 1 && c[i]) crit_esp = 1'b1;
                if (crit_esp && livres == 0) begin
                    for (int i = 0; i < NR; i++)
                        if (rev < 0 && m_st[i] == 2 && m_t[i] > TM && !c[i]) rev = i;
                end
            end
`endif
            for (int i = 0; i < NR; i++) begin
                bit dem;
                dem = p[i] | c[i];
                case (m_st[i])
                    0: if (dem) m_st[i] = 1;
                    1: begin
                        if (sel[i]) begin m_st[i] = 2; m_t[i] = 1; end
                        else if (!dem) m_st[i] = 0;
                    end
                    default: begin
                        if (m_t[i] <= TM) m_t[i]++;
                        else if (!dem)    m_st[i] = 0;
                        else if (i == rev) m_st[i] = 1;
                    end
                endcase
            end
            if (ult >= 0) m_ptr = (ult + 1) % NR;
            m_ocup = 0;
            pc = 0;
            for (int i = 0; i < NR; i++) begin
                if (m_st[i] == 2) m_ocup++;
                if (c[i]) pc++;
            end
            m_sob = (pc > NB) ? 1 : 0;
        end
        for (int i = 0; i < NR; i++) e.conc[i] = (m_st[i] == 2);
        e.ocup = OW'(m_ocup);
        e.sob  = (m_sob != 0);
        fila.push_back(e);
    endtask

    task automatic ciclo(input logic [NR-1:0] p, input logic [NR-1:0] c, input logic r);
        saida_t e;
        pedido  = p;
        critico = c;
        RESET   = r;
        modelo_passo(p, c, r);
        @(posedge CLOCK);
        #1;
        e = fila.pop_front();
        verifica("concessao",  32'(concessao),  32'(e.conc));
        verifica("ocupadas",   32'(ocupadas),   32'(e.ocup));
        verifica("sobrecarga", 32'(sobrecarga), 32'(e.sob));
    endtask

    task automatic rodar(input int n, input logic [NR-1:0] p, input logic [NR-1:0] c);
        for (int k = 0; k < n; k++) ciclo(p, c, 1'b0);
    endtask

    // Reactor 0 was just granted; drop demand and count total cycles held.
    task automatic medir_retencao(input string tag);
        int h;
        bit fim;
        h = 1;
        fim = 1'b0;
        for (int n = 0; n < 3*TM && !fim; n++) begin
            ciclo('0, '0, 1'b0);
            if (concessao[0]) h++;
            else              fim = 1'b1;
        end
        verifica(tag, 32'(h), 32'(TM+1));
    endtask

    initial begin
        pedido  = '0;
        critico = '0;
        RESET   = 1'b1;

        ciclo('0, '0, 1'b1);
        verifica("reset_conc", 32'(concessao), 32'd0);
        verifica("reset_ocup", 32'(ocupadas), 32'd0);

        // single request: two-edge latency, hold through minimum time
        ciclo(4'b0001, '0, 1'b0);
        verifica("latencia_espera", 32'(concessao), 32'd0);
        ciclo(4'b0001, '0, 1'b0);
        verifica("latencia_conc", 32'(concessao), 32'b0001);
        verifica("latencia_ocup", 32'(ocupadas), 32'd1);
        medir_retencao("retencao_t_min");

        // round-robin fairness with all four requesting
        ciclo('0, '0, 1'b1);
        ciclo(4'b1111, '0, 1'b0);
        ciclo(4'b1111, '0, 1'b0);
        verifica("rr_1", 32'(concessao), 32'b0011);
        rodar(TM, 4'b1111, '0);
        ciclo(4'b1100, '0, 1'b0);
        verifica("rr_liberado", 32'(concessao), 32'd0);
        ciclo(4'b1111, '0, 1'b0);
        verifica("rr_2", 32'(concessao), 32'b1100);
        rodar(TM, 4'b1111, '0);
        ciclo(4'b0011, '0, 1'b0);
        ciclo(4'b1111, '0, 1'b0);
        verifica("rr_3", 32'(concessao), 32'b0011);

        // critical waiter beats normal waiter on a freed pump
        ciclo('0, '0, 1'b1);
        rodar(2, 4'b0011, '0);
        rodar(TM, 4'b0011, '0);
        ciclo(4'b0110, 4'b1000, 1'b0);
        verifica("liberacao_0", 32'(concessao), 32'b0010);
        ciclo(4'b0110, 4'b1000, 1'b0);
        verifica("critico_primeiro", 32'(concessao), 32'b1010);

        // overload flag
        ciclo('0, 4'b0111, 1'b0);
        verifica("sobrecarga_1", 32'(sobrecarga), 32'd1);
        ciclo('0, 4'b0011, 1'b0);
        verifica("sobrecarga_0", 32'(sobrecarga), 32'd0);

        // critical arrival while both pumps run normal loads
        ciclo('0, '0, 1'b1);
        rodar(2, 4'b0011, '0);
        rodar(TM, 4'b0011, '0);
        ciclo(4'b0011, 4'b0100, 1'b0);
        verifica("preempcao_0", 32'(concessao), 32'b0011);
        ciclo(4'b0011, 4'b0100, 1'b0);
`ifdef PREEMPCAO_CRITICA_EN
        verifica("preempcao_1", 32'(concessao), 32'b0010);
        ciclo(4'b0011, 4'b0100, 1'b0);
        verifica("preempcao_2", 32'(concessao), 32'b0110);
`else
        verifica("preempcao_1", 32'(concessao), 32'b0011);
        ciclo(4'b0011, 4'b0100, 1'b0);
        verifica("preempcao_2", 32'(concessao), 32'b0011);
`endif

        // reset in the middle of PARTIDA, then full hold on re-request
        ciclo('0, '0, 1'b1);
        rodar(2, 4'b0011, '0);
        ciclo(4'b0011, '0, 1'b1);
        verifica("reset_meio_conc", 32'(concessao), 32'd0);
        verifica("reset_meio_ocup", 32'(ocupadas), 32'd0);
        ciclo(4'b0001, '0, 1'b0);
        ciclo(4'b0001, '0, 1'b0);
        verifica("pos_reset_conc", 32'(concessao), 32'b0001);
        medir_retencao("retencao_pos_reset");

        // random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [NR-1:0] rp, rc;
            logic rr;
            rp = NR'($urandom);
            rc = NR'($urandom & $urandom & $urandom);
            rr = ($urandom_range(0, 63) == 0);
            ciclo(rp, rc, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
        $finish;
    end

endmodule
`default_nettype wire
